// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 500000;   // 10 ms at 50 MHz
    localparam int DEF_MAX_RETRY    = 3;

    // The PLL is held in reset both while being restarted and after giving up.
    function automatic logic holds_pll_rst(input pll_state_t s);
        return (s == S_RESET) || (s == S_FAIL);
    endfunction

endpackage

// File: rtl/pll_lock_sup_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the input; both flops clear on synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sup.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock stability,
// retries on timeout, and releases downstream reset once lock is good.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RESET  | PLL reset held for RST_CYCLES cycles
// S_WAIT   | reset released, waiting for synchronized lock
// S_STABLE | lock seen, counting consecutive locked cycles
// S_RUN    | lock declared good, downstream reset released
// S_FAIL   | retries exhausted, PLL held in reset until relock request
module pll_lock_sup
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             force_relock,
    output logic                             pll_rst,
    output logic                             sys_rst_n,
    output logic                             status_locked,
    output logic                             lol_pulse,
    output logic                             fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    logic              lk_s;
    pll_state_t        state, state_nx;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_nx;
    logic [STB_W-1:0]  stb_cnt, stb_cnt_nx;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nx;
    logic [RTY_W-1:0]  retry_nx;
    logic              lol_nx;

    sync2 u_sync2 (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Next-state and counter update; relock request overrides everything.
    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        stb_cnt_nx = stb_cnt;
        tmo_cnt_nx = tmo_cnt;
        retry_nx   = retry_cnt;
        lol_nx     = 1'b0;

        if (force_relock) begin
            state_nx   = S_RESET;
            rst_cnt_nx = '0;
            stb_cnt_nx = '0;
            tmo_cnt_nx = '0;
            retry_nx   = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state_nx   = S_WAIT;
                        rst_cnt_nx = '0;
                        tmo_cnt_nx = '0;
                    end else begin
                        rst_cnt_nx = rst_cnt + RST_W'(1);
                    end
                end
                S_WAIT, S_STABLE: begin
                    // A completed stability window wins over a coincident timeout.
                    if (state == S_STABLE && lk_s && stb_cnt == STB_LAST) begin
                        state_nx = S_RUN;
                        retry_nx = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rst_cnt_nx = '0;
                        if (retry_cnt == RTY_MAX) begin
                            state_nx = S_FAIL;
                        end else begin
                            state_nx = S_RESET;
                            retry_nx = retry_cnt + RTY_W'(1);
                        end
                    end else begin
                        tmo_cnt_nx = tmo_cnt + TMO_W'(1);
                        if (state == S_WAIT) begin
                            if (lk_s) begin
                                state_nx   = S_STABLE;
                                stb_cnt_nx = '0;
                            end
                        end else if (!lk_s) begin
                            state_nx = S_WAIT;
                        end else begin
                            stb_cnt_nx = stb_cnt + STB_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state_nx   = S_RESET;
                        rst_cnt_nx = '0;
                        lol_nx     = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_nx = S_FAIL;
                end
                default: begin
                    state_nx   = S_RESET;
                    rst_cnt_nx = '0;
                end
            endcase
        end
    end

    // State, counters and outputs decoded from the next state, all on one edge.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state         <= S_RESET;
            rst_cnt       <= '0;
            stb_cnt       <= '0;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            status_locked <= 1'b0;
            lol_pulse     <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nx;
            rst_cnt       <= rst_cnt_nx;
            stb_cnt       <= stb_cnt_nx;
            tmo_cnt       <= tmo_cnt_nx;
            retry_cnt     <= retry_nx;
            pll_rst       <= holds_pll_rst(state_nx);
            sys_rst_n     <= (state_nx == S_RUN);
            status_locked <= (state_nx == S_RUN);
            lol_pulse     <= lol_nx;
            fail          <= (state_nx == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sup.sv
// Self-checking bench for pll_lock_sup with a timeline-based reference model.
module tb_pll_lock_sup;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int MAX_RETRY    = 2;
    localparam int RW           = $clog2(MAX_RETRY + 1);

    logic          refclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          force_relock = 1'b0;
    logic          pll_rst, sys_rst_n, status_locked, lol_pulse, fail;
    logic [RW-1:0] retry_cnt;

    pll_lock_sup #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .status_locked (status_locked),
        .lol_pulse     (lol_pulse),
        .fail          (fail),
        .retry_cnt     (retry_cnt)
    );

    always #10 refclk = ~refclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases tracked by the edge index at which they began.
    localparam int M_RESET = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4;
    int m_mode = M_RESET;
    int m_entry = 0;
    int m_wait_origin = 0;
    int m_stable_entry = 0;
    int m_retries = 0;
    int edge_n = 0;
    bit m_sync_a = 0, m_sync_b = 0, m_lol = 0;
    bit model_valid = 0;

    task automatic enter_reset();
        m_mode  = M_RESET;
        m_entry = edge_n + 1;
    endtask

    task automatic model_step();
        bit lk;
        lk    = m_sync_b;
        m_lol = 0;
        if (!rst_n) begin
            m_mode    = M_RESET;
            m_entry   = edge_n + 1;
            m_retries = 0;
            m_sync_a  = 0;
            m_sync_b  = 0;
        end else begin
            m_sync_b = m_sync_a;
            m_sync_a = pll_locked;
            if (force_relock) begin
                enter_reset();
                m_retries = 0;
            end else begin
                case (m_mode)
                    M_RESET: begin
                        if (edge_n - m_entry == RST_CYCLES - 1) begin
                            m_mode        = M_WAIT;
                            m_wait_origin = edge_n + 1;
                        end
                    end
                    M_WAIT, M_STABLE: begin
                        if (m_mode == M_STABLE && lk && edge_n - m_stable_entry == LOCK_STABLE - 1) begin
                            m_mode    = M_RUN;
                            m_retries = 0;
                        end else if (edge_n - m_wait_origin == LOCK_TIMEOUT - 1) begin
                            if (m_retries == MAX_RETRY) m_mode = M_FAIL;
                            else begin
                                m_retries++;
                                enter_reset();
                            end
                        end else if (m_mode == M_WAIT && lk) begin
                            m_mode         = M_STABLE;
                            m_stable_entry = edge_n + 1;
                        end else if (m_mode == M_STABLE && !lk) begin
                            m_mode = M_WAIT;
                        end
                    end
                    M_RUN: begin
                        if (!lk) begin
                            m_lol = 1;
                            enter_reset();
                        end
                    end
                    default: ;
                endcase
            end
        end
        edge_n++;
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        model_valid = 1;
        @(negedge refclk);
        #1;
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge refclk) begin
        if (model_valid) begin
            chk("pll_rst",       int'(pll_rst),       int'(m_mode == M_RESET || m_mode == M_FAIL));
            chk("sys_rst_n",     int'(sys_rst_n),     int'(m_mode == M_RUN));
            chk("status_locked", int'(status_locked), int'(m_mode == M_RUN));
            chk("fail",          int'(fail),          int'(m_mode == M_FAIL));
            chk("lol_pulse",     int'(lol_pulse),     int'(m_lol));
            chk("retry_cnt",     int'(retry_cnt),     m_retries);
        end
    end

    task automatic wait_run(input string name, input int budget);
        int n;
        n = 0;
        while (!status_locked && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(status_locked), 1);
    endtask

    initial begin
        int first, lol_seen, lol_sys, hi_run, first_retry, first_fail, lost, hold;
        bit run_done, run_seen;

        rst_n = 0; pll_locked = 1; force_relock = 0;
        repeat (3) tick();

        // Release from reset with the PLL already locked.
        rst_n = 1; first = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 2) chk("t1_pll_rst_cycle3", int'(pll_rst), 1);
            if (k == 3) chk("t1_pll_rst_cycle4", int'(pll_rst), 0);
            if (first < 0 && sys_rst_n) first = k + 1;
        end
        chk("t1_first_run_cycle", first, 13);
        chk("t1_status_locked", int'(status_locked), 1);
        chk("t1_retry", int'(retry_cnt), 0);

        // Three-cycle lock dropout while running.
        pll_locked = 0; lol_seen = 0; lol_sys = 1; hi_run = 0; run_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) pll_locked = 1;
            tick();
            if (lol_pulse) begin
                lol_seen++;
                lol_sys = int'(sys_rst_n);
            end
            if (lol_seen > 0 && !run_done) begin
                if (pll_rst) hi_run++;
                else run_done = 1;
            end
        end
        chk("t3_lol_count", lol_seen, 1);
        chk("t3_sys_rst_n_at_lol", lol_sys, 0);
        chk("t3_reset_len", hi_run, 4);
        chk("t3_relocked", int'(status_locked), 1);

        // Relock request on the edge that first sees the lock fall.
        pll_locked = 0;
        tick(); tick();
        force_relock = 1;
        tick();
        force_relock = 0;
        chk("t4_lol", int'(lol_pulse), 0);
        chk("t4_pll_rst", int'(pll_rst), 1);
        chk("t4_retry", int'(retry_cnt), 0);
        chk("t4_sys_rst_n", int'(sys_rst_n), 0);
        lol_seen = 0;
        repeat (10) begin
            tick();
            if (lol_pulse) lol_seen++;
        end
        chk("t4_no_lol_after", lol_seen, 0);

        // Lock toggling every 5 cycles never qualifies; timeout after 64 cycles.
        force_relock = 1; pll_locked = 1;
        tick();
        force_relock = 0;
        first_retry = -1; run_seen = 0;
        for (int t = 1; t <= 80; t++) begin
            if (t % 5 == 0) pll_locked = ~pll_locked;
            tick();
            if (first_retry < 0 && retry_cnt == 1) first_retry = t;
            if (sys_rst_n) run_seen = 1;
        end
        chk("t5_first_retry_cycle", first_retry, 68);
        chk("t5_no_run", int'(run_seen), 0);

        // Lock never arrives: retries exhaust, then failure holds.
        force_relock = 1; pll_locked = 0;
        tick();
        force_relock = 0;
        first_fail = -1; lost = 0; run_seen = 0;
        for (int t = 1; t <= 320; t++) begin
            tick();
            if (t == 68)  chk("t2_retry_1", int'(retry_cnt), 1);
            if (t == 136) chk("t2_retry_2", int'(retry_cnt), 2);
            if (first_fail < 0 && fail) first_fail = t;
            if (t > 204 && (!pll_rst || !fail)) lost++;
            if (sys_rst_n) run_seen = 1;
        end
        chk("t2_first_fail_cycle", first_fail, 204);
        chk("t2_fail_held", lost, 0);
        chk("t2_no_run", int'(run_seen), 0);
        force_relock = 1;
        tick();
        force_relock = 0;
        chk("t2_fail_cleared", int'(fail), 0);
        chk("t2_retry_cleared", int'(retry_cnt), 0);
        chk("t2_fresh_reset", int'(pll_rst), 1);

        // One-cycle reset pulse while running.
        pll_locked = 1;
        wait_run("t6_reach_run", 200);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_pll_rst", int'(pll_rst), 1);
        chk("t6_sys_rst_n", int'(sys_rst_n), 0);
        chk("t6_status", int'(status_locked), 0);
        chk("t6_lol", int'(lol_pulse), 0);
        chk("t6_fail", int'(fail), 0);
        chk("t6_retry", int'(retry_cnt), 0);
        first = -1; lol_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (lol_pulse) lol_seen++;
            if (first < 0 && sys_rst_n) first = k + 1;
        end
        chk("t6_first_run_cycle", first, 13);
        chk("t6_no_lol", lol_seen, 0);

        // Randomized lock behaviour with occasional relock requests and resets.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                pll_locked = ~pll_locked;
                hold = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            hold--;
            force_relock = ($urandom_range(0, 299) == 0);
            rst_n        = ($urandom_range(0, 499) != 0);
            tick();
        end
        force_relock = 0;
        rst_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
